unidade_forwarding: RTL and testbench

Forwarding and load-use hazard control unit for the 5-stage pipeline. It tracks the destination register, write-enable and load flags of the instructions in EX and MEM in a shadow pipeline. It drives the registered `forwardA`/`forwardB` selects consumed by the operand forwarding muxes in EX, and it drives `parar` to stall PC and IF/ID on a load-use hazard. It sits between the decode stage, which supplies the issuing instruction's fields, and the EX-stage operand muxes.

---
 rtl/unidade_forwarding_pkg.sv | 13 +
 rtl/comparador_forwarding.sv | 25 ++
 rtl/unidade_forwarding.sv | 115 +++++++++++
 tb/tb_unidade_forwarding.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/unidade_forwarding_pkg.sv
// Shared constants and state type for the forwarding / load-use hazard unit.
package pacote_forwarding;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef enum logic [0:0] {
        NORMAL,
        BOLHA
    } estadoT;

endpackage

// File: rtl/comparador_forwarding.sv
// Combinational forward select for one EX operand against the EX and MEM shadow registers.
module comparador_forwarding
    import pacote_forwarding::*;
#(
    parameter int unsigned LARGURA_REG = 5
) (
    input  logic [LARGURA_REG-1:0] rs,
    input  logic [LARGURA_REG-1:0] exRd,
    input  logic                   exRw,
    input  logic [LARGURA_REG-1:0] memRd,
    input  logic                   memRw,
    output logic [1:0]             sel
);

    // EX/MEM is the younger producer, so it wins; x0 is hardwired and never forwarded.
    always_comb begin
        sel = FWD_REG;
        if (exRw && (exRd != '0) && (exRd == rs)) begin
            sel = FWD_EX_MEM;
        end else if (memRw && (memRd != '0) && (memRd == rs)) begin
            sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/unidade_forwarding.sv
// Forwarding and load-use stall unit for the 5-stage pipeline.
// Optional bubble counter port contadorBolhas is built when CONTADOR_BOLHAS_EN is defined.
module unidade_forwarding
    import pacote_forwarding::*;
#(
    parameter int unsigned LARGURA_REG = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LARGURA_REG-1:0] rs1ID,
    input  logic [LARGURA_REG-1:0] rs2ID,
    input  logic [LARGURA_REG-1:0] rdID,
    input  logic                   regWriteID,
    input  logic                   memReadID,
    input  logic                   descarte,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic                   parar,
    output logic                   bolha
`ifdef CONTADOR_BOLHAS_EN
    ,
    output logic [31:0]            contadorBolhas
`endif
);

    logic [LARGURA_REG-1:0] exRd;
    logic                   exRw;
    logic                   exMr;
    logic [LARGURA_REG-1:0] memRd;
    logic                   memRw;
    estadoT                 estado;
    estadoT                 estadoProx;
    logic                   hazard;
    logic [1:0]             selA;
    logic [1:0]             selB;

    comparador_forwarding #(
        .LARGURA_REG(LARGURA_REG)
    ) comparadorA (
        .rs   (rs1ID),
        .exRd (exRd),
        .exRw (exRw),
        .memRd(memRd),
        .memRw(memRw),
        .sel  (selA)
    );

    comparador_forwarding #(
        .LARGURA_REG(LARGURA_REG)
    ) comparadorB (
        .rs   (rs2ID),
        .exRd (exRd),
        .exRw (exRw),
        .memRd(memRd),
        .memRw(memRw),
        .sel  (selB)
    );

    // A flush squashes the dependent instruction, so it takes priority over the stall.
    always_comb begin
        hazard = exMr && exRw && (exRd != '0) && ((exRd == rs1ID) || (exRd == rs2ID));
        bolha  = hazard && !descarte && (estado == NORMAL);
        parar  = bolha;

        estadoProx = estado;
        if (descarte) begin
            estadoProx = NORMAL;
        end else if (estado == BOLHA) begin
            estadoProx = NORMAL;
        end else if (bolha) begin
            estadoProx = BOLHA;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            exRd     <= '0;
            exRw     <= 1'b0;
            exMr     <= 1'b0;
            memRd    <= '0;
            memRw    <= 1'b0;
            forwardA <= FWD_REG;
            forwardB <= FWD_REG;
            estado   <= NORMAL;
        end else begin
            memRd  <= exRd;
            memRw  <= exRw;
            estado <= estadoProx;
            if (descarte || bolha) begin
                exRd     <= '0;
                exRw     <= 1'b0;
                exMr     <= 1'b0;
                forwardA <= FWD_REG;
                forwardB <= FWD_REG;
            end else begin
                exRd     <= rdID;
                exRw     <= regWriteID;
                exMr     <= memReadID;
                forwardA <= selA;
                forwardB <= selB;
            end
        end
    end

`ifdef CONTADOR_BOLHAS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            contadorBolhas <= '0;
        end else if (bolha) begin
            contadorBolhas <= contadorBolhas + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unidade_forwarding.sv
// Randomised and directed bench for unidade_forwarding against an instruction-level pipeline model.
module tb_unidade_forwarding;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] rs1ID;
    logic [4:0] rs2ID;
    logic [4:0] rdID;
    logic       regWriteID;
    logic       memReadID;
    logic       descarte;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       parar;
    logic       bolha;
`ifdef CONTADOR_BOLHAS_EN
    logic [31:0] contadorBolhas;
`endif

    always #5 clock = ~clock;

    unidade_forwarding #(
        .LARGURA_REG(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rs1ID         (rs1ID),
        .rs2ID         (rs2ID),
        .rdID          (rdID),
        .regWriteID    (regWriteID),
        .memReadID     (memReadID),
        .descarte      (descarte),
        .forwardA      (forwardA),
        .forwardB      (forwardB),
        .parar         (parar),
        .bolha         (bolha)
`ifdef CONTADOR_BOLHAS_EN
        ,
        .contadorBolhas(contadorBolhas)
`endif
    );

    int erros = 0;
    int total = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
        end
    endtask

    // Model: the instruction occupying EX and MEM, plus whether a bubble was inserted last cycle.
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instrT;

    instrT       emEx;
    instrT       emMem;
    logic [1:0]  fwdAEsp;
    logic [1:0]  fwdBEsp;
    logic        bolhaAnterior;
    int unsigned bolhasEsp;

    function automatic logic [1:0] seleciona(input logic [4:0] rs);
        if (emEx.rw && emEx.rd != 5'd0 && emEx.rd == rs) return 2'b10;
        if (emMem.rw && emMem.rd != 5'd0 && emMem.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic limpaModelo();
        emEx          = '0;
        emMem         = '0;
        fwdAEsp       = 2'b00;
        fwdBEsp       = 2'b00;
        bolhaAnterior = 1'b0;
        bolhasEsp     = 0;
    endtask

    task automatic aplicaReset();
        reset      = 1'b0;
        rs1ID      = '0;
        rs2ID      = '0;
        rdID       = '0;
        regWriteID = 1'b0;
        memReadID  = 1'b0;
        descarte   = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        limpaModelo();
        verifica("rst_fwdA", {30'd0, forwardA}, 32'd0);
        verifica("rst_fwdB", {30'd0, forwardB}, 32'd0);
        #1;
        verifica("rst_parar", {31'd0, parar}, 32'd0);
        verifica("rst_bolha", {31'd0, bolha}, 32'd0);
`ifdef CONTADOR_BOLHAS_EN
        verifica("rst_contador", contadorBolhas, 32'd0);
`endif
    endtask

    // Present one ID instruction for one cycle, check the stall, clock it, check the selects.
    task automatic passo(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic w, input logic m, input logic desc);
        logic       stallEsp;
        logic [1:0] a;
        logic [1:0] b;
        rs1ID      = r1;
        rs2ID      = r2;
        rdID       = d;
        regWriteID = w;
        memReadID  = m;
        descarte   = desc;
        #1;
        stallEsp = emEx.mr && emEx.rw && emEx.rd != 5'd0 && (emEx.rd == r1 || emEx.rd == r2)
                   && !desc && !bolhaAnterior;
        verifica("parar", {31'd0, parar}, {31'd0, stallEsp});
        verifica("bolha", {31'd0, bolha}, {31'd0, stallEsp});
        a     = seleciona(r1);
        b     = seleciona(r2);
        emMem = emEx;
        if (desc || stallEsp) begin
            emEx    = '0;
            fwdAEsp = 2'b00;
            fwdBEsp = 2'b00;
        end else begin
            emEx    = '{rd: d, rw: w, mr: m};
            fwdAEsp = a;
            fwdBEsp = b;
        end
        if (stallEsp) bolhasEsp++;
        bolhaAnterior = stallEsp;
        @(posedge clock);
        #1;
        verifica("forwardA", {30'd0, forwardA}, {30'd0, fwdAEsp});
        verifica("forwardB", {30'd0, forwardB}, {30'd0, fwdBEsp});
`ifdef CONTADOR_BOLHAS_EN
        verifica("contador", contadorBolhas, bolhasEsp);
`endif
    endtask

    initial begin
        limpaModelo();
        aplicaReset();

        // Back-to-back: add x5, then sub reading x5.
        passo(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        passo(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
        verifica("b2b_fwdA", {30'd0, forwardA}, 32'd2);

        // Distance two: add x5, unrelated, reader on rs2.
        passo(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        passo(5'd10, 5'd11, 5'd9, 1'b1, 1'b0, 1'b0);
        passo(5'd12, 5'd5, 5'd13, 1'b1, 1'b0, 1'b0);
        verifica("dist2_fwdB", {30'd0, forwardB}, 32'd1);

        // Double hit on x7: youngest producer wins.
        passo(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        passo(5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        passo(5'd7, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0);
        verifica("dupla_fwdA", {30'd0, forwardA}, 32'd2);

        // Load-use: lw x3, add reading x3 (stalls once, then forwards from MEM/WB).
        aplicaReset();
        passo(5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        passo(5'd3, 5'd4, 5'd15, 1'b1, 1'b0, 1'b0);
        verifica("lu_bolha_fwdA", {30'd0, forwardA}, 32'd0);
        passo(5'd3, 5'd4, 5'd15, 1'b1, 1'b0, 1'b0);
        verifica("lu_retido_fwdA", {30'd0, forwardA}, 32'd1);
`ifdef CONTADOR_BOLHAS_EN
        verifica("lu_contador", contadorBolhas, 32'd1);
`endif

        // x0 is never forwarded and never causes a stall.
        passo(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        passo(5'd0, 5'd2, 5'd16, 1'b1, 1'b0, 1'b0);
        verifica("x0_fwdA", {30'd0, forwardA}, 32'd0);
        passo(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
        passo(5'd0, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0);

        // Flush during a load-use hazard.
        passo(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
        passo(5'd4, 5'd2, 5'd18, 1'b1, 1'b0, 1'b1);
        verifica("desc_fwdA", {30'd0, forwardA}, 32'd0);

        // Reset in the middle of a bubble, then the held instruction again.
        passo(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        passo(5'd3, 5'd2, 5'd19, 1'b1, 1'b0, 1'b0);
        aplicaReset();
        passo(5'd3, 5'd2, 5'd19, 1'b1, 1'b0, 1'b0);
        verifica("rst_bolha_fwdA", {30'd0, forwardA}, 32'd0);

        // Random traffic on a narrow register range to provoke dependencies.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                aplicaReset();
            end else begin
                passo(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end

endmodule
